// File: rtl/debounce_pkg.sv
// Shared constants and types for the push-button debouncer.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT_CYCLES = 16;
    localparam int unsigned DEBOUNCE_10MS_27MHZ     = 270000;

    typedef logic btn_level_t;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs, resetting to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule : sync_2ff

// File: rtl/debouncer.sv
// Push-button debouncer: synchronised input must hold a new level for
// STABLE_CYCLES consecutive edges before the registered output follows it.
module debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic tecla
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    btn_level_t       s2;
    btn_level_t       tecla_q, tecla_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (btn),
        .q     (s2)
    );

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        tecla_d = tecla_q;
        cnt_d   = cnt_q;
        if (s2 == tecla_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            tecla_d = s2;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tecla_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            tecla_q <= tecla_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tecla = tecla_q;

endmodule : debouncer

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: driver pushes expected tecla per edge from a
// sample-history reference model, monitor pops and compares after each edge.
module tb_debouncer;

    localparam int unsigned N = 16;

    logic clk;
    logic rst;
    logic btn;
    logic tecla;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];

    // reference model state: raw samples in flight and visible samples since last change
    logic m_tecla;
    logic btnq[$];
    logic seen[$];

    debouncer #(
        .STABLE_CYCLES (N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .tecla (tecla)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        btnq.delete();
        seen.delete();
        m_tecla = 1'b0;
    endtask

    // tecla changes once the last N filter-visible samples all differ from it
    task automatic model_step(input logic v);
        logic vis;
        int   diff;
        vis = (btnq.size() == 2) ? btnq[0] : 1'b0;
        btnq.push_back(v);
        if (btnq.size() > 2) void'(btnq.pop_front());
        seen.push_back(vis);
        if (seen.size() > N) void'(seen.pop_front());
        diff = 0;
        foreach (seen[i]) if (seen[i] !== m_tecla) diff++;
        if (diff == N) begin
            m_tecla = ~m_tecla;
            seen.delete();
        end
    endtask

    // called at a negedge; returns at the next negedge
    task automatic drive_cycle(input logic val, input bit glitch);
        btn = val;
        model_step(val);
        exp_q.push_back(m_tecla);
        if (glitch) begin
            #2 btn = ~val;
            #3 btn = val;
        end
        @(negedge clk);
    endtask

    task automatic run(input logic val, input int n, input bit glitchy);
        for (int i = 0; i < n; i++) drive_cycle(val, glitchy && ($urandom_range(0, 1) == 1));
    endtask

    always @(posedge clk) begin
        logic e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tecla !== e) begin
                errors++;
                $display("FAIL tecla_scoreboard: got %b, required %b at %0t", tecla, e, $time);
            end
        end
    end

    initial begin
        rst = 1'b0;
        btn = 1'b1;
        model_reset();

        // reset held with btn high
        repeat (5) begin
            @(negedge clk);
            check("reset_tecla", 32'(tecla), 32'd0);
            check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        end
        rst = 1'b1;

        // bounce: short alternating runs with sub-cycle glitches
        for (int r = 0; r < 8; r++) run(logic'(r % 2 == 0), $urandom_range(1, 4), 1'b1);
        check("bounce_press_hold", 32'(tecla), 32'd0);

        // clean press, exact latency
        run(1'b0, 3, 1'b0);
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b1, 1'b0);
            if (i == 16) check("press_before_latency", 32'(tecla), 32'd0);
            if (i == 17) check("press_at_latency", 32'(tecla), 32'd1);
        end
        check("press_stays", 32'(tecla), 32'd1);

        // release with bounce, ending on a high run
        for (int r = 0; r < 8; r++) run(logic'(r % 2 == 1), $urandom_range(1, 4), 1'b1);
        check("bounce_release_hold", 32'(tecla), 32'd1);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 1'b0);
            if (i == 16) check("release_before_latency", 32'(tecla), 32'd1);
            if (i == 17) check("release_at_latency", 32'(tecla), 32'd0);
        end

        // threshold boundary: one sample short, then exactly enough
        run(1'b1, N - 1, 1'b0);
        run(1'b0, 20, 1'b0);
        check("boundary_short", 32'(tecla), 32'd0);
        run(1'b1, N, 1'b0);
        run(1'b0, 3, 1'b0);
        check("boundary_exact", 32'(tecla), 32'd1);
        run(1'b0, 20, 1'b0);
        check("boundary_return", 32'(tecla), 32'd0);

        // reset mid-count
        run(1'b1, 12, 1'b0);
        check("midcount_cnt", 32'(dut.cnt_q), 32'd10);
        #3 rst = 1'b0;
        #1;
        check("async_reset_tecla", 32'(tecla), 32'd0);
        check("async_reset_cnt", 32'(dut.cnt_q), 32'd0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("reset_hold_tecla", 32'(tecla), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 1'b0);
            if (i == 16) check("post_reset_before_latency", 32'(tecla), 32'd0);
            if (i == 17) check("post_reset_at_latency", 32'(tecla), 32'd1);
        end

        // randomized runs around the threshold
        for (int r = 0; r < 600; r++)
            run(logic'($urandom_range(0, 1)), $urandom_range(1, 2 * N - 8), logic'($urandom_range(0, 1)));

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_debouncer
